seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter BLINK_DIV, default 500: number of scan ticks per colon toggle; legal range 2..4095.
REQ-002 Port clk100Mhz  input  1  system clock, 100 MHz; all state is updated on its rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 Port disp_clk  input  1  display refresh clock, ~1 kHz square wave; treated as data, never used as a clock.
REQ-005 Port d3, d2, d1, d0  input  4 each  BCD digits, left to right (HH:MM); d0 is the rightmost digit.
REQ-006 Port an  output  4  digit anodes, active-low, one-hot; an[k] enables digit k.
REQ-007 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 Port dp  output  1  decimal point, active-low; used as the colon.
REQ-009 Port frame  output  1  one-cycle pulse on each frame start.

Function
REQ-010 Synchronizer: disp_clk SHALL pass through three flops (s0, s1, s2); scan_tick = s1 AND NOT s2, active for exactly one clk100Mhz cycle per disp_clk rising edge.
REQ-011 Digit index idx (2 bits) SHALL increment on scan_tick and wrap 3 -> 0.
REQ-012 Frame boundary: on the scan_tick where idx wraps 3 -> 0, d3..d0 SHALL be latched into shadow registers and frame SHALL pulse; the input values present on that cycle are the ones latched.
REQ-013 Inputs SHALL NOT affect the display between frame boundaries, so a frame never mixes old and new values.
REQ-014 an, seg and dp SHALL be registered and updated on the cycle after scan_tick, with an[idx_new] = 0 and all other an bits = 1.
REQ-015 End-to-end latency SHALL be exactly 3 clk100Mhz edges from the first edge that samples disp_clk high to the change of an and seg.
REQ-016 Decode for shadow values 0-9 SHALL follow standard 7-segment patterns: 0 = 1000000, 1 = 1111001, 8 = 0000000, 9 = 0010000.
REQ-017 Shadow values 10-15 SHALL display blank (1111111).
REQ-018 Colon: colon_state SHALL toggle when blink counter bcnt reaches BLINK_DIV-1 on a scan_tick; bcnt then wraps to 0, otherwise bcnt increments per scan_tick.
REQ-019 dp SHALL be 0 only while idx = 2 and colon_state = 1; otherwise dp = 1.
REQ-020 scan_tick and frame SHALL be low in every cycle without a qualifying disp_clk edge; a stalled disp_clk freezes an, seg and dp.

Reset
REQ-021 While rst_n = 0: an = 1111, seg = 1111111, dp = 1, frame = 0.
REQ-022 While rst_n = 0: idx = 3, bcnt = 0, colon_state = 0, shadow registers = 0, s0/s1/s2 = 0.
REQ-023 Reset asserted mid-scan SHALL force the REQ-021/REQ-022 values immediately, without waiting for a clock edge.
REQ-024 After rst_n release, the first scan_tick SHALL be a frame boundary (idx 3 -> 0), latch the inputs and drive an = 1110.

Configuration
REQ-025 Macro LZ_BLANK_EN: when defined, digit 3 SHALL display blank when its shadow value is 0.
REQ-026 When LZ_BLANK_EN is undefined, digit 3 SHALL display 0 normally; all other digits are unaffected in both builds.

Verification (bench uses BLINK_DIV = 4)
REQ-027 Reset release, d3..d0 = 1,2,3,4, one disp_clk rise -> 3 edges later an = 1110, seg = 0011001 (4), frame pulsed once.
REQ-028 Four further disp_clk rises -> an cycles through 1101, 1011, 0111, 1110, showing 3, 2, 1, 4.
REQ-029 Change d0 to 7 while idx = 1 -> digit 0 shows 4 until the next wrap, then shows 7 (1111000).
REQ-030 12 scan ticks -> colon_state toggles at ticks 4, 8 and 12; dp = 0 only on idx = 2 while colon_state = 1.
REQ-031 d3 = 0: with LZ_BLANK_EN defined, digit 3 seg = 1111111; without it, seg = 1000000.
REQ-032 d1 = 12 -> digit 1 shows blank; rst_n pulsed low during a scan -> outputs reach reset values before the next clock edge, and the scan restarts per REQ-024.

Source files
------------

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner (HH:MM) with a blinking colon on digit 2's decimal point.
// Optional macro LZ_BLANK_EN: blank digit 3 when its latched value is 0.
module seg_scan #(
  parameter int BLINK_DIV = 500
) (
  input  logic       clk100Mhz,
  input  logic       rst_n,
  input  logic       disp_clk,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int                BCNT_W    = 12;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

  logic              r_s0, r_s1, r_s2;
  logic              w_scan_tick;
  logic              w_wrap;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [3:0]        r_sh3, r_sh2, r_sh1, r_sh0;
  logic [3:0]        w_sh3_nxt, w_sh2_nxt, w_sh1_nxt, w_sh0_nxt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic              r_colon, w_colon_nxt;
  logic [3:0]        w_digit;
  logic [6:0]        w_seg_nxt;
  logic [3:0]        w_an_nxt;
  logic              w_dp_nxt;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] pat;
    case (v)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Stage: disp_clk synchronizer and rising-edge detect
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s0 <= disp_clk;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  assign w_scan_tick = r_s1 & ~r_s2;
  assign w_wrap      = w_scan_tick & (r_idx == 2'd3);
  assign frame       = w_wrap;

  always_comb begin
    w_idx_nxt   = r_idx;
    w_bcnt_nxt  = r_bcnt;
    w_colon_nxt = r_colon;
    w_sh3_nxt   = r_sh3;
    w_sh2_nxt   = r_sh2;
    w_sh1_nxt   = r_sh1;
    w_sh0_nxt   = r_sh0;
    if (w_scan_tick) begin
      w_idx_nxt = r_idx + 2'd1;
      if (r_bcnt == BCNT_LAST) begin
        w_bcnt_nxt  = '0;
        w_colon_nxt = ~r_colon;
      end else begin
        w_bcnt_nxt = r_bcnt + 1'b1;
      end
    end
    // Inputs only enter at the frame boundary so a frame never mixes old and new digits.
    if (w_wrap) begin
      w_sh3_nxt = d3;
      w_sh2_nxt = d2;
      w_sh1_nxt = d1;
      w_sh0_nxt = d0;
    end
  end

  always_comb begin
    w_digit = w_sh0_nxt;
    case (w_idx_nxt)
      2'd0:    w_digit = w_sh0_nxt;
      2'd1:    w_digit = w_sh1_nxt;
      2'd2:    w_digit = w_sh2_nxt;
      default: w_digit = w_sh3_nxt;
    endcase
    w_seg_nxt = f_decode(w_digit);
`ifdef LZ_BLANK_EN
    if ((w_idx_nxt == 2'd3) && (w_sh3_nxt == 4'd0)) begin
      w_seg_nxt = 7'b1111111;
    end
`endif
    w_an_nxt = ~(4'b0001 << w_idx_nxt);
    w_dp_nxt = ~((w_idx_nxt == 2'd2) && w_colon_nxt);
  end

  // Stage: scan state, shadow digits and blink counter
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 2'd3;
      r_bcnt  <= '0;
      r_colon <= 1'b0;
      r_sh3   <= 4'd0;
      r_sh2   <= 4'd0;
      r_sh1   <= 4'd0;
      r_sh0   <= 4'd0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_colon <= w_colon_nxt;
      r_sh3   <= w_sh3_nxt;
      r_sh2   <= w_sh2_nxt;
      r_sh1   <= w_sh1_nxt;
      r_sh0   <= w_sh0_nxt;
    end
  end

  // Stage: registered display drive, updated one cycle after scan_tick
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_scan_tick) begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (BLINK_DIV = 4): table of per-scan-tick vectors plus
// hand sequences for latency, stall, and asynchronous reset mid-scan.
module tb_seg_scan;

  logic       clk100Mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       disp_clk  = 1'b0;
  logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int n_tests   = 0;
  int n_fail    = 0;
  int frame_cnt = 0;

  seg_scan #(.BLINK_DIV(4)) dut (
    .clk100Mhz (clk100Mhz),
    .rst_n     (rst_n),
    .disp_clk  (disp_clk),
    .d3        (d3),
    .d2        (d2),
    .d1        (d1),
    .d0        (d0),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame     (frame)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  always @(negedge clk100Mhz) begin
    if (frame === 1'b1) frame_cnt++;
  end

  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk100Mhz) disp_clk = 1'b1;
    repeat (4) @(negedge clk100Mhz);
    disp_clk = 1'b0;
    repeat (4) @(negedge clk100Mhz);
  endtask

  task automatic apply_in(input int i);
    d3 = tbl[i].d3; d2 = tbl[i].d2; d1 = tbl[i].d1; d0 = tbl[i].d0;
  endtask

  initial begin
    tbl[0]  = '{4'd1, 4'd2, 4'd3,  4'd4, 4'b1110, 7'b0011001, 1'b1};
    tbl[1]  = '{4'd1, 4'd2, 4'd3,  4'd4, 4'b1101, 7'b0110000, 1'b1};
    tbl[2]  = '{4'd1, 4'd9, 4'd3,  4'd7, 4'b1011, 7'b0100100, 1'b1};
    tbl[3]  = '{4'd1, 4'd9, 4'd3,  4'd7, 4'b0111, 7'b1111001, 1'b1};
    tbl[4]  = '{4'd1, 4'd9, 4'd3,  4'd7, 4'b1110, 7'b1111000, 1'b1};
    tbl[5]  = '{4'd1, 4'd9, 4'd3,  4'd7, 4'b1101, 7'b0110000, 1'b1};
    tbl[6]  = '{4'd1, 4'd9, 4'd3,  4'd7, 4'b1011, 7'b0010000, 1'b0};
    tbl[7]  = '{4'd1, 4'd9, 4'd3,  4'd7, 4'b0111, 7'b1111001, 1'b1};
    tbl[8]  = '{4'd0, 4'd8, 4'd12, 4'd0, 4'b1110, 7'b1000000, 1'b1};
    tbl[9]  = '{4'd0, 4'd8, 4'd12, 4'd0, 4'b1101, 7'b1111111, 1'b1};
    tbl[10] = '{4'd0, 4'd8, 4'd12, 4'd0, 4'b1011, 7'b0000000, 1'b1};
`ifdef LZ_BLANK_EN
    tbl[11] = '{4'd0, 4'd8, 4'd12, 4'd0, 4'b0111, 7'b1111111, 1'b1};
`else
    tbl[11] = '{4'd0, 4'd8, 4'd12, 4'd0, 4'b0111, 7'b1000000, 1'b1};
`endif
    tbl[12] = '{4'd5, 4'd6, 4'd1,  4'd9, 4'b1110, 7'b0010000, 1'b1};
    tbl[13] = '{4'd5, 4'd6, 4'd1,  4'd9, 4'b1101, 7'b1111001, 1'b1};
    tbl[14] = '{4'd5, 4'd6, 4'd1,  4'd9, 4'b1011, 7'b0000010, 1'b0};
    tbl[15] = '{4'd5, 4'd6, 4'd1,  4'd9, 4'b0111, 7'b0010010, 1'b1};

    // Reset state
    repeat (2) @(negedge clk100Mhz);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", dp, 1'b1);
    chk("rst_frame", frame, 1'b0);
    rst_n = 1'b1;
    apply_in(0);
    repeat (2) @(negedge clk100Mhz);

    // First tick: three-edge latency and frame boundary
    disp_clk = 1'b1;
    @(negedge clk100Mhz);
    chk("lat_e1_an", an, 4'b1111);
    @(negedge clk100Mhz);
    chk("lat_e2_an", an, 4'b1111);
    chk("lat_e2_frame", frame, 1'b1);
    @(negedge clk100Mhz);
    chk("lat_e3_an", an, tbl[0].an);
    chk("lat_e3_seg", seg, tbl[0].seg);
    chk("lat_e3_dp", dp, tbl[0].dp);
    chk("lat_e3_frame", frame, 1'b0);
    @(negedge clk100Mhz) disp_clk = 1'b0;
    repeat (4) @(negedge clk100Mhz);
    chk("frame_cnt_t1", frame_cnt, 1);

    // Remaining ticks from the table
    for (int i = 1; i < 16; i++) begin
      apply_in(i);
      pulse();
      chk($sformatf("an_t%0d", i + 1), an, tbl[i].an);
      chk($sformatf("seg_t%0d", i + 1), seg, tbl[i].seg);
      chk($sformatf("dp_t%0d", i + 1), dp, tbl[i].dp);
    end
    chk("frame_cnt_t16", frame_cnt, 4);

    // Stalled disp_clk freezes the display, even with inputs moving
    d3 = 4'd8; d2 = 4'd8; d1 = 4'd8; d0 = 4'd8;
    repeat (20) @(negedge clk100Mhz);
    chk("stall_an", an, tbl[15].an);
    chk("stall_seg", seg, tbl[15].seg);
    chk("stall_dp", dp, tbl[15].dp);
    chk("stall_frame_cnt", frame_cnt, 4);

    // Four more ticks leave colon_state = 1 before the reset
    repeat (4) pulse();
    chk("frame_cnt_t20", frame_cnt, 5);

    // Asynchronous reset mid-scan, asserted between clock edges
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    @(negedge clk100Mhz) disp_clk = 1'b1;
    @(posedge clk100Mhz);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'b1111);
    chk("arst_seg", seg, 7'b1111111);
    chk("arst_dp", dp, 1'b1);
    chk("arst_frame", frame, 1'b0);
    @(negedge clk100Mhz) disp_clk = 1'b0;
    repeat (3) @(negedge clk100Mhz);
    chk("arst_hold_an", an, 4'b1111);
    rst_n = 1'b1;
    repeat (2) @(negedge clk100Mhz);

    // Scan restarts at a frame boundary with fresh colon/blink state
    pulse();
    chk("rs1_an", an, 4'b1110);
    chk("rs1_seg", seg, 7'b0011001);
    chk("rs1_frame_cnt", frame_cnt, 6);
    pulse();
    chk("rs2_an", an, 4'b1101);
    chk("rs2_seg", seg, 7'b0110000);
    pulse();
    chk("rs3_an", an, 4'b1011);
    chk("rs3_seg", seg, 7'b0100100);
    chk("rs3_dp", dp, 1'b1);
    pulse();
    pulse();
    pulse();
    pulse();
    chk("rs7_an", an, 4'b1011);
    chk("rs7_dp", dp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
